wb_arbiter: RTL

- Writeback stage directly upstream of the LemonPC register file. It drives the file's write port (wen/rd/dataD).
- It arbitrates completed results from the ALU and the load/store unit (LSU) using valid/ready handshakes, and registers the winner for one cycle.
- It keeps a per-register pending scoreboard, so decode can stall on a read-after-write hazard.
- It exposes the registered result as a forwarding path.

---
 rtl/wb_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one ALU/LSU result per cycle, registers it onto the
// register-file write port, and tracks per-register pending writes for decode.
module wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] q_rs1,
    input  logic [ADDR_WIDTH-1:0] q_rs2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;
    localparam int unsigned CW   = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        LSU_PRI = 1'b0,
        ALU_PRI = 1'b1
    } grant_t;

    grant_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [NREG-1:0]       pending_q, pending_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  alu_acc, lsu_acc, acc;
    logic                  conflict;
    logic [ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        alu_acc  = 1'b0;
        lsu_acc  = 1'b0;
        conflict = alu_valid && lsu_valid;

        if (conflict) begin
            if (state_q == ALU_PRI) begin
                alu_acc = 1'b1;
            end else begin
                lsu_acc = 1'b1;
                cnt_d   = cnt_inc;
                if (cnt_inc >= CW'(STARVE_MAX)) begin
                    state_d = ALU_PRI;
                end
            end
        end else begin
            alu_acc = alu_valid;
            lsu_acc = lsu_valid;
        end

        // Priority flips back to the LSU only once the ALU has actually been served.
        if (alu_acc && state_q == ALU_PRI) begin
            state_d = LSU_PRI;
        end
    end

    assign acc       = alu_acc || lsu_acc;
    assign acc_rd    = alu_acc ? alu_rd : lsu_rd;
    assign acc_data  = alu_acc ? alu_data : lsu_data;
    assign alu_ready = alu_acc && rst_n;
    assign lsu_ready = lsu_acc && rst_n;

    always_comb begin
        wen_d  = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (acc) begin
            wen_d  = (acc_rd != '0);
            rd_d   = acc_rd;
            data_d = acc_data;
        end
    end

    // Issue is applied after retire so a new producer supersedes the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (acc && acc_rd != '0) begin
            pending_d[acc_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != '0) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LSU_PRI;
            cnt_q     <= '0;
            pending_q <= '0;
            wen_q     <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            wen_q     <= wen_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign busy1   = pending_q[q_rs1];
    assign busy2   = pending_q[q_rs2];
    assign rf_wen  = wen_q;
    assign rf_rd   = rd_q;
    assign rf_data = data_q;

endmodule
